router_dest_reader: RTL and testbench



---
 rtl/router_dest_reader_if.sv | 30 +++
 rtl/router_dest_reader.sv | 134 +++++++++++++
 tb/tb_router_dest_reader.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_dest_reader_if.sv
// FIFO-side and stream-side signals of one router egress port.
// master: the reader (drives read_enb and the stream); slave: the FIFO/sink side.
interface router_dest_reader_if #(
  parameter int DATA_W = 8
);
  logic              vld_out;
  logic [DATA_W-1:0] dout;
  logic              read_enb;
  logic [DATA_W-1:0] pkt_data;
  logic              pkt_valid;
  logic              pkt_ready;
  logic              pkt_sop;
  logic              pkt_eop;
  logic              pkt_done;
  logic              parity_err;
  logic              stall_warn;
  logic              busy;

  modport master (
    input  vld_out, dout, pkt_ready,
    output read_enb, pkt_data, pkt_valid, pkt_sop, pkt_eop,
           pkt_done, parity_err, stall_warn, busy
  );

  modport slave (
    output vld_out, dout, pkt_ready,
    input  read_enb, pkt_data, pkt_valid, pkt_sop, pkt_eop,
           pkt_done, parity_err, stall_warn, busy
  );
endinterface

// File: rtl/router_dest_reader.sv
// Egress reader for one router port: drains the port FIFO into a sop/eop-framed
// ready/valid stream. Define RDR_PARITY_CHK_EN to enable the packet parity check.
module router_dest_reader #(
  parameter int DATA_W     = 8,
  parameter int STALL_WARN = 24
) (
  input logic                  clk,
  input logic                  rstn,
  router_dest_reader_if.master bus
);
  localparam int            CW       = $clog2(STALL_WARN + 1);
  localparam logic [CW-1:0] WARN_MAX = CW'(STALL_WARN);

  typedef enum logic [2:0] {IDLE, HDR_RD, HDR_WAIT, BODY_RD, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [6:0]          remain_q, remain_d;
  logic                rd_pend_q, pend_sop_q, pend_eop_q;
  logic [DATA_W+1:0]   ent0_q, ent1_q;   // {sop, eop, data}
  logic [1:0]          occ_q;
  logic [CW-1:0]       stall_cnt_q;
  logic                done_q;

  logic              credit, issue_ok, rd_en, push, pop, eop_hs;
  logic [DATA_W+1:0] new_ent;

  // Credit counts the byte still in flight from the FIFO so the buffer never overflows.
  assign credit   = (occ_q + 2'(rd_pend_q)) < 2'd2;
  assign issue_ok = (state_q == HDR_RD) || ((state_q == BODY_RD) && (remain_q != 7'd0));
  assign rd_en    = issue_ok && bus.vld_out && credit;
  assign push     = rd_pend_q;
  assign pop      = (occ_q != 2'd0) && bus.pkt_ready;
  assign eop_hs   = pop && ent0_q[DATA_W];
  assign new_ent  = {pend_sop_q, pend_eop_q, bus.dout};

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    case (state_q)
      IDLE:     if (bus.vld_out) state_d = HDR_RD;
      HDR_RD:   if (rd_en) state_d = HDR_WAIT;
      HDR_WAIT: if (rd_pend_q) begin
        remain_d = {1'b0, bus.dout[7:2]} + 7'd1;
        state_d  = BODY_RD;
      end
      BODY_RD:  if (rd_en) begin
        remain_d = remain_q - 7'd1;
        if (remain_q == 7'd1) state_d = DRAIN;
      end
      DRAIN:    if (eop_hs) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      remain_q    <= '0;
      rd_pend_q   <= 1'b0;
      pend_sop_q  <= 1'b0;
      pend_eop_q  <= 1'b0;
      stall_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      rd_pend_q   <= rd_en;
      pend_sop_q  <= rd_en && (state_q == HDR_RD);
      pend_eop_q  <= rd_en && (state_q == BODY_RD) && (remain_q == 7'd1);
      done_q      <= eop_hs;
      if (!bus.vld_out || rd_en)      stall_cnt_q <= '0;
      else if (stall_cnt_q != WARN_MAX) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  // Two-entry skid buffer; entries only shift on a pop so the head holds under backpressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ_q  <= '0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) ent0_q <= new_ent;
          else               ent1_q <= new_ent;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          ent0_q <= ent1_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) ent0_q <= new_ent;
          else begin
            ent0_q <= ent1_q;
            ent1_q <= new_ent;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RDR_PARITY_CHK_EN
  logic [DATA_W-1:0] par_q;
  logic              perr_q;

  // Running XOR restarts on the header and includes the parity byte, so a good packet ends at 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_q  <= '0;
      perr_q <= 1'b0;
    end else begin
      if (push) par_q <= pend_sop_q ? bus.dout : (par_q ^ bus.dout);
      perr_q <= eop_hs && (par_q != '0);
    end
  end

  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.read_enb   = rd_en;
  assign bus.pkt_valid  = (occ_q != 2'd0);
  assign bus.pkt_data   = ent0_q[DATA_W-1:0];
  assign bus.pkt_eop    = ent0_q[DATA_W];
  assign bus.pkt_sop    = ent0_q[DATA_W+1];
  assign bus.pkt_done   = done_q;
  assign bus.stall_warn = (stall_cnt_q == WARN_MAX);
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_router_dest_reader.sv
// Scoreboard bench for router_dest_reader: a FIFO model feeds the reader, a monitor
// checks every stream beat and pkt_done/parity_err against queued expectations.
module tb_router_dest_reader;
  localparam int DATA_W     = 8;
  localparam int STALL_WARN = 24;
`ifdef RDR_PARITY_CHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } beat_t;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  router_dest_reader_if #(.DATA_W(DATA_W)) bus ();

  router_dest_reader #(.DATA_W(DATA_W), .STALL_WARN(STALL_WARN)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int         tests = 0;
  int         fails = 0;
  beat_t      exp_q[$];
  logic       exp_perr_q[$];
  logic [7:0] fifo_q[$];
  logic [7:0] pkt_bytes[$];
  logic       gap = 1'b0;
  logic       pend = 1'b0;
  logic [7:0] pend_byte = '0;
  int         reads = 0;
  int         run = 0;
  logic       prev_warn = 1'b0;
  int         warn_seen = 0;
  int         done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_pkt(input logic hand_err);
    beat_t b;
    for (int i = 0; i < pkt_bytes.size(); i++) begin
      fifo_q.push_back(pkt_bytes[i]);
      b.data = pkt_bytes[i];
      b.sop  = (i == 0);
      b.eop  = (i == pkt_bytes.size() - 1);
      exp_q.push_back(b);
    end
    exp_perr_q.push_back(CHK & hand_err);
  endtask

  task automatic wait_done(input string name, input int target);
    int n = 0;
    while (done_cnt < target && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    check({name, "_done"}, 32'(done_cnt >= target), 32'd1);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Router FIFO model: a byte popped by a read is presented on dout one cycle later.
  initial begin
    bus.vld_out   = 1'b0;
    bus.dout      = '0;
    bus.pkt_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        pend        = 1'b0;
        bus.vld_out = 1'b0;
        run         = 0;
      end else begin
        if (pend) bus.dout = pend_byte;
        pend        = 1'b0;
        bus.vld_out = (fifo_q.size() > 0) && !gap;
        #1;
        if (bus.stall_warn && !prev_warn) check("stall_onset_run", 32'(run), 32'(STALL_WARN));
        prev_warn = bus.stall_warn;
        if (bus.stall_warn) warn_seen++;
        if (bus.vld_out && !bus.read_enb) run++;
        else                              run = 0;
        if (bus.read_enb) begin
          if (fifo_q.size() == 0) check("overread", 32'd1, 32'd0);
          else begin
            pend_byte = fifo_q.pop_front();
            pend      = 1'b1;
            reads++;
          end
        end
      end
    end
  end

  // Monitor: compares each accepted beat and each pkt_done against the scoreboard.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rstn) begin
        if (bus.pkt_valid && bus.pkt_ready) begin
          if (exp_q.size() == 0) check("unexpected_beat", {22'd0, bus.pkt_data, bus.pkt_sop, bus.pkt_eop}, 32'd0);
          else begin
            e = exp_q.pop_front();
            check("beat", {22'd0, bus.pkt_data, bus.pkt_sop, bus.pkt_eop}, {22'd0, e});
          end
        end
        if (bus.pkt_done) begin
          done_cnt++;
          if (exp_perr_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
          else check("parity_err", 32'(bus.parity_err), 32'(exp_perr_q.pop_front()));
        end else if (bus.parity_err) begin
          check("perr_without_done", 32'd1, 32'd0);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         r0;
    int         rmid;
    int         n;
    int         w0;
    int         tgt;
    logic [10:0] hold;

    // Reset
    #2 rstn = 1'b0;
    #1;
    check("reset_ctrl", {24'd0, bus.read_enb, bus.pkt_valid, bus.pkt_sop, bus.pkt_eop,
                         bus.pkt_done, bus.parity_err, bus.stall_warn, bus.busy}, 32'd0);
    check("reset_data", {24'd0, bus.pkt_data}, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.pkt_ready = 1'b1;

    // len=3 addr=1, good parity (0x0D^A1^B2^C3 = 0xDD)
    r0 = reads;
    pkt_bytes = '{8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDD};
    load_pkt(1'b0);
    wait_done("len3_good", 1);
    check("len3_good_reads", 32'(reads - r0), 32'd5);

    // Same packet, corrupted parity byte
    r0 = reads;
    pkt_bytes = '{8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDE};
    load_pkt(1'b1);
    wait_done("len3_bad", 2);
    check("len3_bad_reads", 32'(reads - r0), 32'd5);

    // len=0
    r0 = reads;
    pkt_bytes = '{8'h02, 8'h02};
    load_pkt(1'b0);
    wait_done("len0", 3);
    check("len0_reads", 32'(reads - r0), 32'd2);

    // len=10 with a 30-cycle backpressure stall after the 2nd beat
    r0 = reads;
    pkt_bytes = '{8'h2A, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
                  8'h16, 8'h17, 8'h18, 8'h19, 8'h2B};
    load_pkt(1'b0);
    n = 0;
    while (exp_q.size() > 10 && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("stall_two_beats", 32'(exp_q.size()), 32'd10);
    @(posedge clk);
    #1 bus.pkt_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    hold = {bus.pkt_valid, bus.pkt_sop, bus.pkt_eop, bus.pkt_data};
    rmid = reads;
    repeat (25) @(posedge clk);
    #1;
    check("stall_no_read", 32'(reads - rmid), 32'd0);
    check("stall_buffered_le2", 32'((reads - r0) <= 4), 32'd1);
    check("stall_warn_level", 32'(bus.stall_warn), 32'd1);
    check("stall_head_hold", {21'd0, bus.pkt_valid, bus.pkt_sop, bus.pkt_eop, bus.pkt_data}, {21'd0, hold});
    bus.pkt_ready = 1'b1;
    wait_done("len10_stall", 4);
    check("len10_reads", 32'(reads - r0), 32'd12);
    check("stall_warn_cleared", 32'(bus.stall_warn), 32'd0);

    // len=4 with vld_out low for 5 cycles mid-payload (0x11^01^02^04^08 = 0x1E)
    r0 = reads;
    w0 = warn_seen;
    pkt_bytes = '{8'h11, 8'h01, 8'h02, 8'h04, 8'h08, 8'h1E};
    load_pkt(1'b0);
    n = 0;
    while ((reads - r0) < 3 && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    gap  = 1'b1;
    rmid = reads;
    repeat (5) @(negedge clk);
    #2;
    check("gap_no_read", 32'(reads - rmid), 32'd0);
    gap = 1'b0;
    wait_done("gap", 5);
    check("gap_reads", 32'(reads - r0), 32'd6);
    check("gap_no_warn", 32'(warn_seen - w0), 32'd0);

    // Back-to-back: len=0 then len=3, both queued at once
    r0 = reads;
    pkt_bytes = '{8'h02, 8'h02};
    load_pkt(1'b0);
    pkt_bytes = '{8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDD};
    load_pkt(1'b0);
    wait_done("b2b", 7);
    check("b2b_reads", 32'(reads - r0), 32'd7);

    // Asynchronous reset mid-body
    r0 = reads;
    pkt_bytes = '{8'h18, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'h00};
    load_pkt(1'b0);
    n = 0;
    while ((reads - r0) < 3 && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    #1 rstn = 1'b0;
    #1;
    check("async_reset_ctrl", {24'd0, bus.read_enb, bus.pkt_valid, bus.pkt_sop, bus.pkt_eop,
                               bus.pkt_done, bus.parity_err, bus.stall_warn, bus.busy}, 32'd0);
    check("async_reset_data", {24'd0, bus.pkt_data}, 32'd0);
    fifo_q.delete();
    exp_q.delete();
    exp_perr_q.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_idle", {29'd0, bus.busy, bus.pkt_valid, bus.read_enb}, 32'd0);

    // Recovery after reset
    tgt = done_cnt + 1;
    pkt_bytes = '{8'h02, 8'h02};
    load_pkt(1'b0);
    wait_done("post_reset_pkt", tgt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
